// File: rtl/avg_iir_pkg.sv
// Shared constants, types and helpers for the averaging IIR front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avg_iir_pkg;

  // Default sample width feeding the IIR stage.
  localparam int DATA_W_DEF = 24;

  // Width of the saturating overrun drop counter.
  localparam int OVR_CNT_W = 16;

  // Sequencer FSM: IDLE holds no frame, SEND streams the active frame.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } seq_state_t;

  // Channel-index width; a single-channel build still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iir_frame_hold.sv
// One-entry frame register with a full flag, loaded and popped by the owner.
// Latency: loaded data and full flag visible the cycle after i_load.
// Backpressure: owner must only load when empty and only pop when full.
module iir_frame_hold #(
  parameter int W = 48
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full
);

  logic [W-1:0] data_q;
  logic         full_q;

  // Capture a frame on load; the full flag tracks load/pop, contents persist until the next load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (i_load) begin
        data_q <= i_data;
      end
      if (i_load) begin
        full_q <= 1'b1;
      end else if (i_pop) begin
        full_q <= 1'b0;
      end
    end
  end

  assign o_data = data_q;
  assign o_full = full_q;

endmodule

// File: rtl/iir_chan_sequencer.sv
// Buffers up to two multi-channel frames and streams them one channel per beat, tagged with the index.
// Latency: frame accepted at cycle t gives ch0 at t+1; one beat per cycle while i_s_ready is high.
// Backpressure: stalled beats hold stable; o_frame_ready falls while the hold slot is full and extra frames drop with o_overrun.
// Optional: define IIR_CHAN_SEQ_OVERRUN_CNT_EN to add the saturating o_overrun_cnt drop counter.
module iir_chan_sequencer
  import avg_iir_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int N_CH    = 2,
  localparam int CH_W    = ch_w(N_CH),
  localparam int FRAME_W = N_CH * DATA_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_valid,
  input  logic [FRAME_W-1:0] i_frame_data,
  output logic               o_frame_ready,
  output logic               o_s_valid,
  input  logic               i_s_ready,
  output logic [DATA_W-1:0]  o_s_data,
  output logic [CH_W-1:0]    o_s_ch,
  output logic               o_s_last,
  output logic               o_overrun
`ifdef IIR_CHAN_SEQ_OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] o_overrun_cnt
`endif
);

  seq_state_t         state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [FRAME_W-1:0] active_q, active_d;
  logic [FRAME_W-1:0] hold_data;
  logic               hold_full, hold_load, hold_pop;
  logic               accept, handshake, ch_last;

  // hold_full is itself a flop, so frame-ready is a registered output.
  assign o_frame_ready = !hold_full;
  assign accept        = i_frame_valid && !hold_full;
  assign handshake     = (state_q == SEND) && i_s_ready;
  assign ch_last       = (ch_q == CH_W'(N_CH - 1));

  iir_frame_hold #(
    .W (FRAME_W)
  ) u_hold (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (hold_load),
    .i_pop   (hold_pop),
    .i_data  (i_frame_data),
    .o_data  (hold_data),
    .o_full  (hold_full)
  );

  // State, channel pointer and active frame registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      active_q <= active_d;
    end
  end

  // Next state: fill active directly when it is free, otherwise park in hold; refill on the last beat without a bubble.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    active_d  = active_q;
    hold_load = 1'b0;
    hold_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          active_d = i_frame_data;
          ch_d     = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (handshake && ch_last) begin
          ch_d = '0;
          if (hold_full) begin
            active_d = hold_data;
            hold_pop = 1'b1;
          end else if (accept) begin
            active_d = i_frame_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) begin
            ch_d = ch_q + 1'b1;
          end
          hold_load = accept;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_s_valid = (state_q == SEND);
  assign o_s_data  = active_q[int'(ch_q) * DATA_W +: DATA_W];
  assign o_s_ch    = ch_q;
  assign o_s_last  = o_s_valid && ch_last;
  // A frame strobe while the hold slot is occupied is lost; flag it in the same cycle.
  assign o_overrun = i_frame_valid && hold_full;

`ifdef IIR_CHAN_SEQ_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  // Count dropped frames, sticking at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovr_cnt_q <= '0;
    end else if (o_overrun && (ovr_cnt_q != '1)) begin
      ovr_cnt_q <= ovr_cnt_q + 1'b1;
    end
  end

  assign o_overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_iir_chan_sequencer.sv
// Self-checking bench: two instances (2-channel and 1-channel) against a frame-queue reference model.
// Latency: n/a.
// Backpressure: randomized downstream ready and frame strobes.
module tb_iir_chan_sequencer;

  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Two-channel instance signals
  logic          va, ra;
  logic [2*DW-1:0] da;
  logic          a_frdy, a_sv, a_sl, a_ovr;
  logic [DW-1:0] a_sd;
  logic [0:0]    a_sch;
  logic [15:0]   a_cnt;

  // One-channel instance signals
  logic          vb, rb;
  logic [DW-1:0] db;
  logic          b_frdy, b_sv, b_sl, b_ovr;
  logic [DW-1:0] b_sd;
  logic [0:0]    b_sch;
  logic [15:0]   b_cnt;

  iir_chan_sequencer #(.DATA_W(DW), .N_CH(2)) dut_a (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_valid (va),
    .i_frame_data  (da),
    .o_frame_ready (a_frdy),
    .o_s_valid     (a_sv),
    .i_s_ready     (ra),
    .o_s_data      (a_sd),
    .o_s_ch        (a_sch),
    .o_s_last      (a_sl),
    .o_overrun     (a_ovr)
`ifdef IIR_CHAN_SEQ_OVERRUN_CNT_EN
    ,
    .o_overrun_cnt (a_cnt)
`endif
  );

  iir_chan_sequencer #(.DATA_W(DW), .N_CH(1)) dut_b (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_valid (vb),
    .i_frame_data  (db),
    .o_frame_ready (b_frdy),
    .o_s_valid     (b_sv),
    .i_s_ready     (rb),
    .o_s_data      (b_sd),
    .o_s_ch        (b_sch),
    .o_s_last      (b_sl),
    .o_overrun     (b_ovr)
`ifdef IIR_CHAN_SEQ_OVERRUN_CNT_EN
    ,
    .o_overrun_cnt (b_cnt)
`endif
  );

`ifndef IIR_CHAN_SEQ_OVERRUN_CNT_EN
  assign a_cnt = '0;
  assign b_cnt = '0;
`endif

  // Reference model: queues of frames not yet fully sent (at most two: active + hold).
  logic [2*DW-1:0] qa[$];
  int              ha;    // next channel of the head frame
  logic [DW-1:0]   qb[$];
  int              cnta, cntb;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2*DW-1:0] fa;
    check_eq("a_valid", a_sv, qa.size() > 0);
    check_eq("a_frame_ready", a_frdy, qa.size() < 2);
    check_eq("a_overrun", a_ovr, va && (qa.size() >= 2));
    if (qa.size() > 0) begin
      fa = qa[0];
      check_eq("a_data", a_sd, fa[ha*DW +: DW]);
      check_eq("a_ch", a_sch, ha);
      check_eq("a_last", a_sl, ha == 1);
    end else begin
      check_eq("a_last_idle", a_sl, 0);
    end
    check_eq("b_valid", b_sv, qb.size() > 0);
    check_eq("b_frame_ready", b_frdy, qb.size() < 2);
    check_eq("b_overrun", b_ovr, vb && (qb.size() >= 2));
    if (qb.size() > 0) begin
      check_eq("b_data", b_sd, qb[0]);
      check_eq("b_ch", b_sch, 0);
      check_eq("b_last", b_sl, 1);
    end
`ifdef IIR_CHAN_SEQ_OVERRUN_CNT_EN
    check_eq("a_overrun_cnt", a_cnt, cnta);
    check_eq("b_overrun_cnt", b_cnt, cntb);
`endif
  endtask

  // Check current outputs, then advance one clock and apply the same inputs to the model.
  task automatic step();
    logic hs, acc, drop;
    #1;
    check_outputs();
    @(posedge clk);
    hs   = (qa.size() > 0) && ra;
    acc  = va && (qa.size() < 2);
    drop = va && (qa.size() >= 2);
    if (hs) begin
      if (ha == 1) begin
        void'(qa.pop_front());
        ha = 0;
      end else begin
        ha++;
      end
    end
    if (acc) qa.push_back(da);
    if (drop && cnta < 65535) cnta++;
    hs   = (qb.size() > 0) && rb;
    acc  = vb && (qb.size() < 2);
    drop = vb && (qb.size() >= 2);
    if (hs) void'(qb.pop_front());
    if (acc) qb.push_back(db);
    if (drop && cntb < 65535) cntb++;
    #1;
  endtask

  task automatic drain();
    va = 1'b0; vb = 1'b0; ra = 1'b1; rb = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    rst_n = 1'b0;
    va = 1'b0; vb = 1'b0; ra = 1'b1; rb = 1'b1;
    da = '0; db = '0;
    ha = 0; cnta = 0; cntb = 0;
    #1;
    check_outputs();
    check_eq("rst_a_data", a_sd, 0);
    check_eq("rst_a_ch", a_sch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, ready high: ch0 then ch1 then idle.
    va = 1'b1; da = {24'h000002, 24'h000001};
    step();
    va = 1'b0;
    check_eq("t1_ch0_data", a_sd, 24'h000001);
    check_eq("t1_ch0_valid", a_sv, 1);
    step();
    check_eq("t1_ch1_data", a_sd, 24'h000002);
    check_eq("t1_ch1_last", a_sl, 1);
    step();
    check_eq("t1_idle_valid", a_sv, 0);
    drain();

    // Same frame with five stalled cycles.
    va = 1'b1; da = {24'h000002, 24'h000001};
    step();
    va = 1'b0; ra = 1'b0;
    repeat (5) step();
    ra = 1'b1;
    drain();

    // Back-to-back frames plus a third that must be dropped.
    va = 1'b1; da = {24'h000002, 24'h000001};
    step();
    da = {24'h0000BB, 24'h0000AA};
    step();
    check_eq("t3_ready_low", a_frdy, 0);
    da = {24'h0000CC, 24'h0000DD};
    check_eq("t3_overrun", a_ovr, 1);
    step();
    va = 1'b0;
    check_eq("t3_third_beat", a_sd, 24'h0000AA);
    drain();

    // Asynchronous reset after the ch0 handshake.
    va = 1'b1; da = {24'h000002, 24'h000001};
    step();
    va = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", a_sv, 0);
    check_eq("rst_mid_data", a_sd, 0);
    check_eq("rst_mid_ch", a_sch, 0);
    check_eq("rst_mid_last", a_sl, 0);
    check_eq("rst_mid_ready", a_frdy, 1);
    check_eq("rst_mid_overrun", a_ovr, 0);
    qa.delete(); qb.delete(); ha = 0; cnta = 0; cntb = 0;
    #1;
    rst_n = 1'b1;
    va = 1'b1; da = {24'h000004, 24'h000003};
    step();
    va = 1'b0;
    check_eq("rst_after_ch0", a_sd, 24'h000003);
    drain();

    // Single-channel instance: extreme values back-to-back.
    vb = 1'b1; db = 24'h7FFFFF;
    step();
    db = 24'h800000;
    check_eq("n1_first_data", b_sd, 24'h7FFFFF);
    check_eq("n1_first_last", b_sl, 1);
    step();
    vb = 1'b0;
    check_eq("n1_second_data", b_sd, 24'h800000);
    drain();

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      va = ($urandom_range(0, 2) == 0);
      vb = ($urandom_range(0, 2) == 0);
      ra = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 3) != 0);
      da = {24'($urandom()), 24'($urandom())};
      db = 24'($urandom());
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
